// File: rtl/ppf_mac_sched.sv
// ppf_mac_sched: time-multiplexed tap scheduler for a direct-form polyphase filter.
//
// Accepts one sample per s_axis handshake into a TAPS-deep delay line. It then steps an
// external registered mult_add (p_out = p_in + a_in*b_in, one cycle) through every tap and
// presents the formatted dot product on m_axis.
//
// Ports:
//   clk_i, rstn_i                    clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready       sample input (signed DWIDTH)
//   m_axis_tdata/tvalid/tready       filtered output (OWIDTH)
//   cfg_we_i, cfg_addr_i, cfg_data_i coefficient write port, honoured only when idle
//   cfg_busy_o                       high while coefficient writes are ignored
//   mac_a_o, mac_b_o, mac_p_o        drive mult_add a_in, b_in, p_in
//   mac_p_i                          mult_add p_out
//
// Build option: define PPF_SCHED_ROUND_EN to round half-up and saturate the output.
// Without it, the output is an arithmetic right shift truncated (wrapping) to OWIDTH.
module ppf_mac_sched #(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned CWIDTH    = 16,
  parameter int unsigned TAPS      = 8,
  parameter int unsigned ACC_WIDTH = 36,
  parameter int unsigned SHIFT     = 16,
  parameter int unsigned OWIDTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [DWIDTH-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [OWIDTH-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       cfg_we_i,
  input  logic [$clog2(TAPS)-1:0]    cfg_addr_i,
  input  logic [CWIDTH-1:0]          cfg_data_i,
  output logic                       cfg_busy_o,
  output logic [DWIDTH-1:0]          mac_a_o,
  output logic [CWIDTH-1:0]          mac_b_o,
  output logic [ACC_WIDTH-1:0]       mac_p_o,
  input  logic [ACC_WIDTH-1:0]       mac_p_i
);

  localparam int unsigned KW = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MAC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [DWIDTH-1:0] dly_q  [TAPS];
  logic [CWIDTH-1:0] coef_q [TAPS];
  logic [OWIDTH-1:0] out_q;
  logic              out_vld_q;
  logic              idle;
  logic              s_hs;
  logic [OWIDTH-1:0] out_fmt;

  assign idle = (state_q == ST_IDLE);
  assign s_hs = idle && s_axis_tvalid;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s_axis_tvalid) state_d = ST_MAC;
      ST_MAC:   if (k_q == K_LAST) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT:   if (m_axis_tready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_MAC) && (k_q != K_LAST)) k_q <= k_q + 1'b1;
      else                                         k_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line and coefficient bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(TAPS); i++) dly_q[i] <= '0;
    end else if (s_hs) begin
      dly_q[0] <= s_axis_tdata;
      for (int i = 1; i < int'(TAPS); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // A write coinciding with a sample accept lands at that edge, ahead of the first MAC cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(TAPS); i++) coef_q[i] <= '0;
    end else if (idle && cfg_we_i && (32'(cfg_addr_i) < TAPS)) begin
      coef_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // MAC operand steering; zeros outside MAC so the shared multiplier sees no stray data
  // ---------------------------------------------------------------------------
  always_comb begin
    mac_a_o = '0;
    mac_b_o = '0;
    mac_p_o = '0;
    if (state_q == ST_MAC) begin
      mac_a_o = dly_q[k_q];
      mac_b_o = coef_q[k_q];
      mac_p_o = (k_q == '0) ? '0 : mac_p_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Output formatting, evaluated on the completed sum during DRAIN
  // ---------------------------------------------------------------------------
  logic signed [ACC_WIDTH:0] sum_ext;
  logic signed [ACC_WIDTH:0] sum_sh;

  assign sum_ext = {mac_p_i[ACC_WIDTH-1], mac_p_i};

`ifdef PPF_SCHED_ROUND_EN
  localparam logic [ACC_WIDTH:0] ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND_ADD = (SHIFT > 0) ? (ONE << RND_POS) : '0;
  localparam logic signed [ACC_WIDTH:0] O_MAX = (ONE << (OWIDTH - 1)) - ONE;
  localparam logic signed [ACC_WIDTH:0] O_MIN = ~O_MAX;

  logic signed [ACC_WIDTH:0] sum_rnd;

  // One extra bit of headroom means the rounding add cannot overflow.
  assign sum_rnd = sum_ext + RND_ADD;
  assign sum_sh  = sum_rnd >>> SHIFT;

  always_comb begin
    if (sum_sh > O_MAX)      out_fmt = O_MAX[OWIDTH-1:0];
    else if (sum_sh < O_MIN) out_fmt = O_MIN[OWIDTH-1:0];
    else                     out_fmt = sum_sh[OWIDTH-1:0];
  end
`else
  logic unused_sh;

  assign sum_sh    = sum_ext >>> SHIFT;
  assign out_fmt   = sum_sh[OWIDTH-1:0];
  // High bits are intentionally discarded: overflow wraps.
  assign unused_sh = ^sum_sh[ACC_WIDTH:OWIDTH];
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (state_q == ST_DRAIN) begin
      out_q     <= out_fmt;
      out_vld_q <= 1'b1;
    end else if (out_vld_q && m_axis_tready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign s_axis_tready = idle;
  assign cfg_busy_o    = !idle;
  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = out_vld_q;

endmodule

// File: tb/tb_ppf_mac_sched.sv
// Bench for ppf_mac_sched: three instances share stimulus (TAPS=4), differing only in output
// format (A: SHIFT=0/OWIDTH=16, B: SHIFT=2/OWIDTH=16, C: SHIFT=0/OWIDTH=8). A behavioural
// filter model pushes expected outputs when samples are accepted; tasks pop and compare them.
module tb_ppf_mac_sched;
  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int hs_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        m_tready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;

  logic        s_rdy_a, s_rdy_b, s_rdy_c, m_vld_a, m_vld_b, m_vld_c, busy_a, busy_b, busy_c;
  logic [15:0] m_data_a, m_data_b;
  logic [7:0]  m_data_c;
  logic [15:0] mac_a_a, mac_a_b, mac_a_c, mac_b_a, mac_b_b, mac_b_c;
  logic [35:0] mac_p_a, mac_p_b, mac_p_c, macq_a, macq_b, macq_c;

  ppf_mac_sched #(.DWIDTH(16), .CWIDTH(16), .TAPS(TAPS), .ACC_WIDTH(36), .SHIFT(0),
                  .OWIDTH(16)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_rdy_a), .m_axis_tdata(m_data_a), .m_axis_tvalid(m_vld_a),
    .m_axis_tready(m_tready), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_busy_o(busy_a), .mac_a_o(mac_a_a), .mac_b_o(mac_b_a), .mac_p_o(mac_p_a),
    .mac_p_i(macq_a));

  ppf_mac_sched #(.DWIDTH(16), .CWIDTH(16), .TAPS(TAPS), .ACC_WIDTH(36), .SHIFT(2),
                  .OWIDTH(16)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_rdy_b), .m_axis_tdata(m_data_b), .m_axis_tvalid(m_vld_b),
    .m_axis_tready(m_tready), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_busy_o(busy_b), .mac_a_o(mac_a_b), .mac_b_o(mac_b_b), .mac_p_o(mac_p_b),
    .mac_p_i(macq_b));

  ppf_mac_sched #(.DWIDTH(16), .CWIDTH(16), .TAPS(TAPS), .ACC_WIDTH(36), .SHIFT(0),
                  .OWIDTH(8)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_rdy_c), .m_axis_tdata(m_data_c), .m_axis_tvalid(m_vld_c),
    .m_axis_tready(m_tready), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
    .cfg_busy_o(busy_c), .mac_a_o(mac_a_c), .mac_b_o(mac_b_c), .mac_p_o(mac_p_c),
    .mac_p_i(macq_c));

  // mult_add models: registered p_out = p_in + a_in*b_in, all signed.
  always @(posedge clk) begin
    macq_a <= $signed(mac_p_a) + $signed(mac_a_a) * $signed(mac_b_a);
    macq_b <= $signed(mac_p_b) + $signed(mac_a_b) * $signed(mac_b_b);
    macq_c <= $signed(mac_p_c) + $signed(mac_a_c) * $signed(mac_b_c);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_vld_a && m_tready) hs_cnt <= hs_cnt + 1;
  end

  logic [252:0] rst_view;
  assign rst_view = {s_rdy_a, s_rdy_b, s_rdy_c, m_vld_a, m_vld_b, m_vld_c, busy_a, busy_b,
                     busy_c, m_data_a, m_data_b, m_data_c, mac_a_a, mac_b_a, mac_p_a, mac_a_b,
                     mac_b_b, mac_p_b, mac_a_c, mac_b_c, mac_p_c};
  localparam logic [252:0] RST_EXP = {3'b111, 250'd0};

  // Filter model and scoreboard
  logic signed [15:0] m_coef [TAPS];
  logic signed [15:0] m_d [TAPS];
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic [7:0]  q_c [$];
  int acc_cyc = 0;

  function automatic longint fmt(input longint s, input int sh, input int ow);
    longint r;
`ifdef PPF_SCHED_ROUND_EN
    longint hi, lo;
    r = (sh > 0) ? ((s + (longint'(1) << (sh - 1))) >>> sh) : s;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = s >>> sh;
`endif
    return r & ((longint'(1) << ow) - 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = '0;
      m_d[i] = '0;
    end
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  task automatic write_coef(input int a, input int v);
    cfg_we = 1'b1;
    cfg_addr = 2'(a);
    cfg_data = 16'(v);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_coef[a] = 16'(v);
  endtask

  // Offers a sample (optionally with a simultaneous coefficient write) until accepted.
  task automatic put_sample(input int x, input logic we, input int wa, input int wv);
    longint sum;
    int n;
    n = 0;
    s_tdata = 16'(x);
    s_tvalid = 1'b1;
    cfg_we = we;
    cfg_addr = 2'(wa);
    cfg_data = 16'(wv);
    forever begin
      @(negedge clk);
      if (s_rdy_a) break;
      n++;
      if (n > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: s_axis_tready stayed %b, required 1", s_rdy_a);
        s_tvalid = 1'b0;
        cfg_we = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    cfg_we = 1'b0;
    acc_cyc = cyc;
    if (we) m_coef[wa] = 16'(wv);
    for (int i = TAPS - 1; i > 0; i--) m_d[i] = m_d[i-1];
    m_d[0] = 16'(x);
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += longint'(m_d[i]) * longint'(m_coef[i]);
    q_a.push_back(16'(fmt(sum, 0, 16)));
    q_b.push_back(16'(fmt(sum, 2, 16)));
    q_c.push_back(8'(fmt(sum, 0, 8)));
  endtask

  // Waits for m_axis_tvalid; completes the handshake only when m_tready is high.
  task automatic get_out(output logic [15:0] oa, output logic [15:0] ob, output logic [7:0] oc,
                         output int lat);
    int n;
    n = 0;
    oa = '0;
    ob = '0;
    oc = '0;
    lat = -1;
    forever begin
      @(negedge clk);
      if (m_vld_a) break;
      n++;
      if (n > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL output_timeout: m_axis_tvalid stayed %b, required 1", m_vld_a);
        return;
      end
    end
    oa = m_data_a;
    ob = m_data_b;
    oc = m_data_c;
    lat = cyc - acc_cyc;
    if (m_tready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat;
    #12;
    n_tests++;
    if (rst_view !== RST_EXP) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", rst_view, RST_EXP);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // Cleared coefficients give zero for any input; zeros then flush the delay line.
    for (int i = 0; i < 5; i++) begin
      put_sample((i == 0) ? 5 : 0, 1'b0, 0, 0);
      get_out(oa, ob, oc, lat);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      n_tests++;
      if ({oa, ob, oc} !== {ea, eb, ec}) begin
        n_fail++;
        $display("FAIL reset_coef_zero[%0d]: got %h/%h/%h required %h/%h/%h", i, oa, ob, oc,
                 ea, eb, ec);
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat;
    int lit [4] = '{1, 2, 3, 4};
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
    for (int i = 0; i < 4; i++) begin
      put_sample((i == 0) ? 1 : 0, 1'b0, 0, 0);
      get_out(oa, ob, oc, lat);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      n_tests++;
      if ({oa, ob, oc} !== {ea, eb, ec} || oa !== 16'(lit[i])) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got %h/%h/%h required %h/%h/%h (a=%0d)", i, oa, ob, oc,
                 ea, eb, ec, lit[i]);
      end
      n_tests++;
      if (lat !== TAPS + 1) begin
        n_fail++;
        $display("FAIL impulse_latency[%0d]: got %0d required %0d", i, lat, TAPS + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat, prev;
    int xs [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, -1, -1};
    int lit [11] = '{1, 3, 6, 10, 10, 9, 7, 4, 0, -1, -3};
    prev = 0;
    for (int i = 0; i < 11; i++) begin
      put_sample(xs[i], 1'b0, 0, 0);
      n_tests++;
      if (i > 0 && acc_cyc - prev !== TAPS + 3) begin
        n_fail++;
        $display("FAIL throughput[%0d]: got %0d cycles required %0d", i, acc_cyc - prev,
                 TAPS + 3);
      end
      prev = acc_cyc;
      get_out(oa, ob, oc, lat);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      n_tests++;
      if ({oa, ob, oc} !== {ea, eb, ec} || oa !== 16'(lit[i])) begin
        n_fail++;
        $display("FAIL step[%0d]: got %h/%h/%h required %h/%h/%h (a=%0d)", i, oa, ob, oc,
                 ea, eb, ec, lit[i]);
      end
      if (i == 2) begin
        n_tests++;
`ifdef PPF_SCHED_ROUND_EN
        if (ob !== 16'd2) begin
`else
        if (ob !== 16'd1) begin
`endif
          n_fail++;
          $display("FAIL rounding_sum6: got %0d", ob);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa, ob, ea, eb, held;
    logic [7:0] oc, ec;
    int lat, c0, h0;
    m_tready = 1'b0;
    put_sample(1, 1'b0, 0, 0);
    get_out(oa, ob, oc, lat);
    held = oa;
    s_tvalid = 1'b1;
    s_tdata = 16'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({m_vld_a, m_data_a, s_rdy_a} !== {1'b1, held, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b data=%h rdy=%b required 1/%h/0",
                 i, m_vld_a, m_data_a, s_rdy_a, held);
      end
    end
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ec = q_c.pop_front();
    n_tests++;
    if ({oa, ob, oc} !== {ea, eb, ec}) begin
      n_fail++;
      $display("FAIL backpressure_data: got %h/%h/%h required %h/%h/%h", oa, ob, oc, ea, eb, ec);
    end
    // Release with a sample already pending: it must be taken the cycle after the handshake.
    c0 = cyc;
    h0 = hs_cnt;
    m_tready = 1'b1;
    put_sample(9, 1'b0, 0, 0);
    n_tests++;
    if (acc_cyc - c0 !== 2 || hs_cnt - h0 !== 1) begin
      n_fail++;
      $display("FAIL release: got accept at +%0d with %0d handshakes required +2 with 1",
               acc_cyc - c0, hs_cnt - h0);
    end
    get_out(oa, ob, oc, lat);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ec = q_c.pop_front();
    n_tests++;
    if ({oa, ob, oc} !== {ea, eb, ec}) begin
      n_fail++;
      $display("FAIL after_release: got %h/%h/%h required %h/%h/%h", oa, ob, oc, ea, eb, ec);
    end
  endtask

  task automatic test_cfg_busy();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat;
    for (int i = 0; i < 6; i++) begin
      // i<4: zeros (last one carries a write attempt in MAC); i=4: impulse;
      // i=5: sample with a write in the same IDLE cycle.
      if (i == 5) put_sample(2, 1'b1, 0, 3);
      else        put_sample((i == 4) ? 1 : 0, 1'b0, 0, 0);
      if (i == 3) begin
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 16'd7;
        @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1) begin
          n_fail++;
          $display("FAIL cfg_busy: got %b required 1", busy_a);
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
      end
      get_out(oa, ob, oc, lat);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      n_tests++;
      if ({oa, ob, oc} !== {ea, eb, ec} || (i == 4 && oa !== 16'd1) || (i == 5 && oa !== 16'd8))
      begin
        n_fail++;
        $display("FAIL cfg[%0d]: got %h/%h/%h required %h/%h/%h", i, oa, ob, oc, ea, eb, ec);
      end
    end
    write_coef(0, 1);
  endtask

  task automatic test_saturation();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat;
    for (int i = 0; i < 5; i++) begin
      put_sample((i == 4) ? 300 : 0, 1'b0, 0, 0);
      get_out(oa, ob, oc, lat);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      n_tests++;
      if ({oa, ob, oc} !== {ea, eb, ec}) begin
        n_fail++;
        $display("FAIL sat_flow[%0d]: got %h/%h/%h required %h/%h/%h", i, oa, ob, oc,
                 ea, eb, ec);
      end
    end
    n_tests++;
`ifdef PPF_SCHED_ROUND_EN
    if (oc !== 8'd127 || oa !== 16'd300) begin
`else
    if (oc !== 8'd44 || oa !== 16'd300) begin
`endif
      n_fail++;
      $display("FAIL saturation_300: got c=%0d a=%0d", oc, oa);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] oa, ob, ea, eb;
    logic [7:0] oc, ec;
    int lat;
    put_sample(7, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    // Second MAC cycle: operands are d[1]=300 and coef[1]=2.
    n_tests++;
    if ({busy_a, mac_a_a, mac_b_a} !== {1'b1, 16'd300, 16'd2}) begin
      n_fail++;
      $display("FAIL mid_mac_operands: got busy=%b a=%0d b=%0d required 1/300/2", busy_a,
               mac_a_a, mac_b_a);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (rst_view !== RST_EXP) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", rst_view, RST_EXP);
    end
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 5);
    put_sample(1, 1'b0, 0, 0);
    get_out(oa, ob, oc, lat);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    ec = q_c.pop_front();
    n_tests++;
    if ({oa, ob, oc} !== {ea, eb, ec} || oa !== 16'd5) begin
      n_fail++;
      $display("FAIL post_reset_impulse: got %h/%h/%h required %h/%h/%h", oa, ob, oc,
               ea, eb, ec);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_back_to_back();
    test_backpressure();
    test_cfg_busy();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
